// File: rtl/square1_freq_sweep.sv
// square1_freq_sweep: frequency sweep unit for square channel 1. It keeps a
// shadow copy of the 11-bit frequency and periodically adds or subtracts
// (shadow >> shift) to it under NR10 control.
// Latency: every output comes straight from a register, so each one reflects the
// clock edge that caused it.
// Backpressure: none. Strobes are taken on the cycle they are presented.
//
// Ports:
//   system_clock        single clock for all logic
//   reset               synchronous, active-low; clears all state
//   sweep_tick          one-cycle 128 Hz strobe
//   nr14_wr             one-cycle strobe: NR14 written this cycle
//   NR10                [6:4] period P, [3] negate, [2:0] shift S
//   NR13 / NR14         CPU frequency bytes (NR14[7] = trigger, [2:0] = freq high)
//   internal_NR13/14    swept frequency bytes presented to the wave generator
//   enable_square_wave  channel enable (0 = mute, drops on overflow)
//
// Optional build macro SWEEP_NEG_LOCKOUT_EN: after a sweep step has been taken
// in negate mode, clearing NR10[3] mutes the channel until the next trigger.

module square1_freq_sweep #(
   parameter int FREQ_W   = 11,
   parameter int FREQ_MAX = 2047
) (
   input  logic       system_clock,
   input  logic       reset,
   input  logic       sweep_tick,
   input  logic       nr14_wr,
   input  logic [7:0] NR10,
   input  logic [7:0] NR13,
   input  logic [7:0] NR14,
   output logic [7:0] internal_NR13,
   output logic [7:0] internal_NR14,
   output logic       enable_square_wave
);

   // Overflow limit at the widened calc width (one extra bit for the add carry).
   localparam logic [FREQ_W:0] MAX_V = (FREQ_W + 1)'(FREQ_MAX);

   // ---------------------------------------------------------------
   // Register decode
   // ---------------------------------------------------------------
   logic [2:0] sweep_period;
   logic       negate;
   logic [2:0] shift;
   logic       unused_nr10_bit;

   assign sweep_period    = NR10[6:4];
   assign negate          = NR10[3];
   assign shift           = NR10[2:0];
   assign unused_nr10_bit = NR10[7];

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [FREQ_W-1:0] shadow, shadow_d;
   logic [2:0]        timer, timer_d;        // 0 encodes a count of 8
   logic              sweep_en, sweep_en_d;
   logic              chan_en, chan_en_d;
   logic [4:0]        nr14_hi, nr14_hi_d;    // NR14[7:3] passthrough, latched on write
`ifdef SWEEP_NEG_LOCKOUT_EN
   logic              neg_used, neg_used_d;
`endif

   // ---------------------------------------------------------------
   // Sweep arithmetic
   // ---------------------------------------------------------------
   // Add/subtract is done one bit wider than the frequency, so an add that
   // leaves the legal range shows up as a value above MAX_V.  The subtract
   // path cannot go below zero, because delta never exceeds the value it is
   // taken from.
   function automatic logic [FREQ_W:0] calc_sum(input logic [FREQ_W-1:0] val,
                                                input logic [2:0]        sh,
                                                input logic              neg);
      logic [FREQ_W:0] ext;
      logic [FREQ_W:0] delta;
      ext   = {1'b0, val};
      delta = ext >> sh;
      return neg ? (ext - delta) : (ext + delta);
   endfunction

   logic              trig;
   logic              tick;
   logic [FREQ_W-1:0] load_val;
   logic [FREQ_W:0]   trig_sum;
   logic              trig_ovf;
   logic [FREQ_W:0]   cur_sum;
   logic              cur_ovf;
   logic [FREQ_W-1:0] cur_next;
   logic [FREQ_W:0]   sec_sum;
   logic              sec_ovf;

   assign trig     = nr14_wr & NR14[7];
   assign tick     = sweep_tick & ~trig;     // a trigger swallows a coincident tick
   assign load_val = FREQ_W'({NR14[2:0], NR13});

   // Check made against the value being loaded by a trigger.
   assign trig_sum = calc_sum(load_val, shift, negate);
   assign trig_ovf = !negate && (trig_sum > MAX_V);

   // First calc on the current shadow value.
   assign cur_sum  = calc_sum(shadow, shift, negate);
   assign cur_ovf  = !negate && (cur_sum > MAX_V);
   assign cur_next = cur_sum[FREQ_W-1:0];

   // Look-ahead calc on the value about to be written back. Only its
   // overflow flag is kept; the sum itself is thrown away.
   assign sec_sum  = calc_sum(cur_next, shift, negate);
   assign sec_ovf  = !negate && (sec_sum > MAX_V);

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      shadow_d   = shadow;
      timer_d    = timer;
      sweep_en_d = sweep_en;
      chan_en_d  = chan_en;
      nr14_hi_d  = nr14_hi;
`ifdef SWEEP_NEG_LOCKOUT_EN
      neg_used_d = neg_used;
`endif

      // Any write to NR14 refreshes the passthrough bits.
      if (nr14_wr) begin
         nr14_hi_d = NR14[7:3];
      end

      if (trig) begin
         shadow_d   = load_val;
         timer_d    = sweep_period;              // P==0 lands on the "8" encoding
         sweep_en_d = (sweep_period != 3'd0) || (shift != 3'd0);
         chan_en_d  = !((shift != 3'd0) && trig_ovf);
`ifdef SWEEP_NEG_LOCKOUT_EN
         neg_used_d = 1'b0;
`endif
      end else begin
         if (tick) begin
            if (timer != 3'd1) begin
               timer_d = timer - 3'd1;          // 0 (=8) wraps to 7
            end else begin
               timer_d = sweep_period;
               // A muted channel keeps its frequency frozen until retriggered.
               if (sweep_en && (sweep_period != 3'd0) && chan_en) begin
                  if (cur_ovf) begin
                     chan_en_d = 1'b0;
                  end else if (shift != 3'd0) begin
                     shadow_d = cur_next;
                     if (sec_ovf) begin
                        chan_en_d = 1'b0;
                     end
                  end
`ifdef SWEEP_NEG_LOCKOUT_EN
                  neg_used_d = negate;
`endif
               end
            end
         end
`ifdef SWEEP_NEG_LOCKOUT_EN
         // Leaving negate mode after a negate step has been taken mutes the channel.
         if (neg_used && !negate) begin
            chan_en_d = 1'b0;
         end
`endif
      end
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge system_clock) begin
      if (!reset) begin
         shadow   <= '0;
         timer    <= 3'd0;
         sweep_en <= 1'b0;
         chan_en  <= 1'b0;
         nr14_hi  <= 5'd0;
`ifdef SWEEP_NEG_LOCKOUT_EN
         neg_used <= 1'b0;
`endif
      end else begin
         shadow   <= shadow_d;
         timer    <= timer_d;
         sweep_en <= sweep_en_d;
         chan_en  <= chan_en_d;
         nr14_hi  <= nr14_hi_d;
`ifdef SWEEP_NEG_LOCKOUT_EN
         neg_used <= neg_used_d;
`endif
      end
   end

   // ---------------------------------------------------------------
   // Outputs (all register-driven)
   // ---------------------------------------------------------------
   assign internal_NR13      = shadow[7:0];
   assign internal_NR14      = {nr14_hi, shadow[10:8]};
   assign enable_square_wave = chan_en;

endmodule
